// File: rtl/mul_initiator.sv
// mul_initiator: takes an operand pair, starts a multiplier core, waits for it
// with a bounded timer, and holds the product (or a timeout error) until
// downstream accepts it. op_count counts delivered results.
module mul_initiator #(
  parameter int W       = 2,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           mul_start,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_result,
  input  logic           mul_done,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_result,
  output logic           out_err,
  output logic [15:0]    op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;

  // The WAIT phase lasts at most TIMEOUT cycles: the last one is the cycle
  // in which the timer holds TIMEOUT-1.
  localparam logic [8:0] TMO_LAST = 9'(TIMEOUT - 1);

  state_e          state_q;
  logic [W-1:0]    a_q, b_q;
  logic [2*W-1:0]  res_q;
  logic            err_q;
  logic [8:0]      timer_q;
  logic [15:0]     cnt_q;

  // Handshake and strobe outputs are plain decodes of the registered state.
  assign in_ready   = (state_q == IDLE);
  assign mul_start  = (state_q == ISSUE);
  assign out_valid  = (state_q == HOLD);
  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign out_result = res_q;
  assign out_err    = err_q;
  assign op_count   = cnt_q;

  // Control FSM and all datapath registers; mul_done is only looked at in WAIT,
  // so a late completion from an abandoned operation cannot leak through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (mul_done) begin
            // completion wins even in the final timeout cycle
            res_q   <= mul_result;
            err_q   <= 1'b0;
            state_q <= HOLD;
          end else if (timer_q == TMO_LAST) begin
            res_q   <= '0;
            err_q   <= 1'b1;
            state_q <= HOLD;
          end else begin
            timer_q <= timer_q + 9'd1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            cnt_q   <= cnt_q + 16'd1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
